// File: rtl/tdm128_codec_responder.sv
// TDM128 codec responder: 4-slot x 32-bit TDM slave. Receives DAC words on sdin and
// returns ADC words on sdout, framed by the master's bick/lrck, all in the clk_256fs domain.
module tdm128_codec_responder #(
    parameter int unsigned W = 16
) (
    input  logic         clk_256fs,
    input  logic         rst,
    input  logic         bick,
    input  logic         lrck,
    input  logic         sdin,
    output logic         sdout,
    input  logic [W-1:0] adc_sample_in0,
    input  logic [W-1:0] adc_sample_in1,
    input  logic [W-1:0] adc_sample_in2,
    input  logic [W-1:0] adc_sample_in3,
    output logic [W-1:0] dac_sample_out0,
    output logic [W-1:0] dac_sample_out1,
    output logic [W-1:0] dac_sample_out2,
    output logic [W-1:0] dac_sample_out3,
    output logic         dac_valid,
    output logic         frame_start,
    output logic         sync_err
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [0:0] {StSyncWait, StRun} state_e;

    state_e       state_q;
    logic         bick_q, lrck_q;
    logic [7:0]   bitpos_q;
    logic         frame_ok_q;
    logic [W-1:0] rx_q [4];
    logic [W-1:0] tx_q [4];
    logic [W-1:0] dac_q [4];
    logic         sdout_q, dac_valid_q, frame_start_q, sync_err_q;

    logic          rise, fall, boundary, lrck_rise, run;
    logic          err_rise, err_short, err_long;
    logic [1:0]    slot;
    logic [4:0]    bit_idx;
    logic          bit_live;
    logic [IW-1:0] sel;

    assign rise      = bick & ~bick_q;
    assign fall      = ~bick & bick_q;
    assign boundary  = fall & ~lrck & lrck_q;
    assign lrck_rise = lrck & ~lrck_q;
    assign run       = (state_q == StRun);

    // Framing checks only apply once locked; before that bitpos is free-running.
    assign err_rise  = run & lrck_rise & (bitpos_q != 8'd64);
    assign err_short = run & boundary & (bitpos_q != 8'd128);
    assign err_long  = run & rise & (bitpos_q == 8'd128);

    assign slot     = bitpos_q[6:5];
    assign bit_idx  = bitpos_q[4:0];
    assign bit_live = (32'(bit_idx) < W) && !bitpos_q[7];
    assign sel      = IW'(W - 32'd1 - 32'(bit_idx));

    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            state_q       <= StSyncWait;
            bick_q        <= 1'b0;
            lrck_q        <= 1'b0;
            bitpos_q      <= '0;
            frame_ok_q    <= 1'b0;
            sdout_q       <= 1'b0;
            dac_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                rx_q[n]  <= '0;
                tx_q[n]  <= '0;
                dac_q[n] <= '0;
            end
        end else begin
            bick_q        <= bick;
            lrck_q        <= lrck;
            dac_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= err_rise | err_short | err_long;

            if (rise) bitpos_q <= bitpos_q + 8'd1;

            case (state_q)
                StSyncWait: sdout_q <= 1'b0;
                StRun: begin
                    if (rise && bit_live) rx_q[slot][sel] <= sdin;
                    if (fall) sdout_q <= bit_live ? tx_q[slot][sel] : 1'b0;
                    if (err_rise || err_long) begin
                        state_q    <= StSyncWait;
                        sdout_q    <= 1'b0;
                        frame_ok_q <= 1'b0;
                    end
                end
                default: state_q <= StSyncWait;
            endcase

            // Boundary actions win over the per-bit drive above.
            if (boundary) begin
                tx_q[0]       <= adc_sample_in0;
                tx_q[1]       <= adc_sample_in1;
                tx_q[2]       <= adc_sample_in2;
                tx_q[3]       <= adc_sample_in3;
                sdout_q       <= adc_sample_in0[W-1];
                frame_start_q <= 1'b1;
                bitpos_q      <= '0;
                state_q       <= StRun;
                frame_ok_q    <= ~err_short;
                if (run && frame_ok_q && !err_short) begin
                    for (int n = 0; n < 4; n++) dac_q[n] <= rx_q[n];
                    dac_valid_q <= 1'b1;
                end
            end
        end
    end

    assign sdout           = sdout_q;
    assign dac_valid       = dac_valid_q;
    assign frame_start     = frame_start_q;
    assign sync_err        = sync_err_q;
    assign dac_sample_out0 = dac_q[0];
    assign dac_sample_out1 = dac_q[1];
    assign dac_sample_out2 = dac_q[2];
    assign dac_sample_out3 = dac_q[3];

endmodule

// File: tb/tb_tdm128_codec_responder.sv
// Bench for tdm128_codec_responder: a W=16 and a W=24 instance share one TDM master model;
// expected DAC frames are queued when sent and compared when dac_valid fires.
module tb_tdm128_codec_responder;

    logic clk_256fs = 1'b0;
    logic rst = 1'b1;
    logic bick = 1'b0;
    logic lrck = 1'b0;
    logic sdin = 1'b0;

    logic [15:0] adc16 [4];
    logic [23:0] adc24 [4];
    logic [15:0] d16 [4];
    logic [23:0] d24 [4];
    logic sdout16, dv16, fs16, se16;
    logic sdout24, dv24, fs24, se24;

    int checks = 0;
    int errors = 0;
    int fs_cnt = 0;
    int se_cnt = 0;
    int dv_cnt = 0;

    logic [63:0] exp16 [$];
    logic [95:0] exp24 [$];
    logic [63:0] e16;
    logic [95:0] e24;

    always #5 clk_256fs = ~clk_256fs;

    tdm128_codec_responder #(.W(16)) u_dut16 (
        .clk_256fs      (clk_256fs),
        .rst            (rst),
        .bick           (bick),
        .lrck           (lrck),
        .sdin           (sdin),
        .sdout          (sdout16),
        .adc_sample_in0 (adc16[0]),
        .adc_sample_in1 (adc16[1]),
        .adc_sample_in2 (adc16[2]),
        .adc_sample_in3 (adc16[3]),
        .dac_sample_out0(d16[0]),
        .dac_sample_out1(d16[1]),
        .dac_sample_out2(d16[2]),
        .dac_sample_out3(d16[3]),
        .dac_valid      (dv16),
        .frame_start    (fs16),
        .sync_err       (se16)
    );

    tdm128_codec_responder #(.W(24)) u_dut24 (
        .clk_256fs      (clk_256fs),
        .rst            (rst),
        .bick           (bick),
        .lrck           (lrck),
        .sdin           (sdin),
        .sdout          (sdout24),
        .adc_sample_in0 (adc24[0]),
        .adc_sample_in1 (adc24[1]),
        .adc_sample_in2 (adc24[2]),
        .adc_sample_in3 (adc24[3]),
        .dac_sample_out0(d24[0]),
        .dac_sample_out1(d24[1]),
        .dac_sample_out2(d24[2]),
        .dac_sample_out3(d24[3]),
        .dac_valid      (dv24),
        .frame_start    (fs24),
        .sync_err       (se24)
    );

    // Scoreboard side: pulses counted, DAC words popped and compared on dac_valid.
    always @(negedge clk_256fs) begin
        if (!rst) begin
            if (fs16) fs_cnt++;
            if (se16) se_cnt++;
            if (dv16) begin
                dv_cnt++;
                checks++;
                if (exp16.size() == 0) begin
                    errors++;
                    $display("FAIL dac16_unexpected got %h", {d16[0], d16[1], d16[2], d16[3]});
                end else begin
                    e16 = exp16.pop_front();
                    if ({d16[0], d16[1], d16[2], d16[3]} !== e16) begin
                        errors++;
                        $display("FAIL dac16_words got %h want %h",
                                 {d16[0], d16[1], d16[2], d16[3]}, e16);
                    end
                end
            end
            if (dv24) begin
                checks++;
                if (exp24.size() == 0) begin
                    errors++;
                    $display("FAIL dac24_unexpected got %h", {d24[0], d24[1], d24[2], d24[3]});
                end else begin
                    e24 = exp24.pop_front();
                    if ({d24[0], d24[1], d24[2], d24[3]} !== e24) begin
                        errors++;
                        $display("FAIL dac24_words got %h want %h",
                                 {d24[0], d24[1], d24[2], d24[3]}, e24);
                    end
                end
            end
        end
    end

    function automatic logic [127:0] tx16_model();
        return {adc16[0], 16'h0, adc16[1], 16'h0, adc16[2], 16'h0, adc16[3], 16'h0};
    endfunction

    function automatic logic [127:0] tx24_model();
        return {adc24[0], 8'h0, adc24[1], 8'h0, adc24[2], 8'h0, adc24[3], 8'h0};
    endfunction

    // Random slot data with the padding byte driven to all ones.
    function automatic logic [127:0] rand_frame();
        logic [127:0] w;
        for (int s = 0; s < 4; s++) w[127-32*s -: 32] = {24'($urandom()), 8'hFF};
        return w;
    endfunction

    task automatic push_exp(input logic [127:0] w);
        exp16.push_back({w[127:112], w[95:80], w[63:48], w[31:16]});
        exp24.push_back({w[127:104], w[95:72], w[63:40], w[31:8]});
    endtask

    task automatic do_reset();
        bick = 1'b0; lrck = 1'b0; sdin = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk_256fs);
        #1 rst = 1'b0;
        fs_cnt = 0; se_cnt = 0; dv_cnt = 0;
        exp16.delete(); exp24.delete();
    endtask

    // One BICK period: falling edge presents lrck/sdin, sdout is read as bick goes high.
    task automatic master_bit(input logic lr, input logic din, input bit stretch,
                              output logic o16, output logic o24);
        @(posedge clk_256fs); #1;
        bick = 1'b0; lrck = lr; sdin = din;
        @(posedge clk_256fs); #1;
        bick = 1'b1;
        o16 = sdout16; o24 = sdout24;
        if (stretch) begin
            @(posedge clk_256fs); #1;
        end
    endtask

    task automatic preamble();
        logic o16, o24;
        for (int i = 0; i < 8; i++) master_bit(1'b1, 1'b0, 1'b0, o16, o24);
    endtask

    task automatic send_frame(input logic [127:0] words, input int len, input int rise_at,
                              input int stretch_at, input int rst_at,
                              output logic [127:0] cap16, output logic [127:0] cap24);
        logic o16, o24;
        cap16 = '0; cap24 = '0;
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                @(posedge clk_256fs); #1 rst = 1'b1;
                @(posedge clk_256fs); #1 rst = 1'b0;
                checks++;
                if ({sdout16, dv16, fs16, se16, d16[0], d16[1], d16[2], d16[3],
                     sdout24, dv24, fs24, se24, d24[0], d24[1], d24[2], d24[3]} !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_outputs got %b%b%b%b %h %h want all zero",
                             sdout16, dv16, fs16, se16, {d16[0], d16[1], d16[2], d16[3]},
                             {d24[0], d24[1], d24[2], d24[3]});
                end
            end
            master_bit((i >= rise_at), words[127-i], (i == stretch_at), o16, o24);
            cap16[127-i] = o16;
            cap24[127-i] = o24;
        end
    endtask

    task automatic close_frame();
        logic o16, o24;
        master_bit(1'b0, 1'b0, 1'b0, o16, o24);
        repeat (4) @(posedge clk_256fs);
        #1;
    endtask

    task automatic test_reset();
        bick = 1'b1; lrck = 1'b1; sdin = 1'b1; rst = 1'b1;
        repeat (3) @(posedge clk_256fs);
        #1;
        checks++;
        if ({sdout16, dv16, fs16, se16, d16[0], d16[1], d16[2], d16[3]} !== '0) begin
            errors++;
            $display("FAIL reset_dut16 got %b%b%b%b %h want zero", sdout16, dv16, fs16, se16,
                     {d16[0], d16[1], d16[2], d16[3]});
        end
        checks++;
        if ({sdout24, dv24, fs24, se24, d24[0], d24[1], d24[2], d24[3]} !== '0) begin
            errors++;
            $display("FAIL reset_dut24 got %b%b%b%b %h want zero", sdout24, dv24, fs24, se24,
                     {d24[0], d24[1], d24[2], d24[3]});
        end
    endtask

    task automatic test_loopback();
        logic [127:0] w, c16, c24;
        do_reset();
        adc16 = '{16'hA5A5, 16'h0001, 16'h8000, 16'h5A5A};
        adc24 = '{24'hA5A5C3, 24'h000001, 24'h800000, 24'h5A5A3C};
        preamble();
        w = {16'h1234, 16'h5AFF, 16'h8001, 16'h00FF, 16'h7FFF, 16'hC3FF, 16'hFFFF, 16'h0FFF};
        push_exp(w);
        send_frame(w, 128, 64, -1, -1, c16, c24);
        checks++;
        if (c16 !== tx16_model()) begin
            errors++; $display("FAIL loop_tx16 got %h want %h", c16, tx16_model());
        end
        checks++;
        if (c24 !== tx24_model()) begin
            errors++; $display("FAIL loop_tx24 got %h want %h", c24, tx24_model());
        end
        adc16 = '{16'h7FFF, 16'hFFFF, 16'h0F0F, 16'h1357};
        adc24 = '{24'h7FFFFF, 24'hFFFFFF, 24'h0F0F0F, 24'h135790};
        w = rand_frame();
        push_exp(w);
        send_frame(w, 128, 64, -1, -1, c16, c24);
        checks++;
        if (c16 !== tx16_model()) begin
            errors++; $display("FAIL b2b_tx16 got %h want %h", c16, tx16_model());
        end
        checks++;
        if (c24 !== tx24_model()) begin
            errors++; $display("FAIL pad_tx24 got %h want %h", c24, tx24_model());
        end
        close_frame();
        checks++;
        if (fs_cnt !== 3) begin errors++; $display("FAIL loop_fs_count got %0d want 3", fs_cnt); end
        checks++;
        if (dv_cnt !== 2) begin errors++; $display("FAIL loop_dv_count got %0d want 2", dv_cnt); end
        checks++;
        if (se_cnt !== 0) begin errors++; $display("FAIL loop_se_count got %0d want 0", se_cnt); end
        checks++;
        if (exp16.size() + exp24.size() != 0) begin
            errors++; $display("FAIL loop_pending got %0d want 0", exp16.size() + exp24.size());
        end
    endtask

    task automatic test_lrck_early();
        logic [127:0] w, c16, c24;
        do_reset();
        preamble();
        w = rand_frame();
        push_exp(w);
        send_frame(w, 128, 64, -1, -1, c16, c24);
        send_frame(rand_frame(), 128, 63, -1, -1, c16, c24);
        checks++;
        if ({c16[64:0], c24[64:0]} !== '0) begin
            errors++; $display("FAIL early_sdout_zero got %h %h want 0", c16[64:0], c24[64:0]);
        end
        checks++;
        if (se_cnt !== 1) begin errors++; $display("FAIL early_se_count got %0d want 1", se_cnt); end
        w = rand_frame();
        push_exp(w);
        send_frame(w, 128, 64, -1, -1, c16, c24);
        checks++;
        if (dv_cnt !== 1) begin
            errors++; $display("FAIL early_no_valid got %0d want 1", dv_cnt);
        end
        close_frame();
        checks++;
        if (fs_cnt !== 4) begin errors++; $display("FAIL early_fs_count got %0d want 4", fs_cnt); end
        checks++;
        if (dv_cnt !== 2) begin errors++; $display("FAIL early_dv_count got %0d want 2", dv_cnt); end
        checks++;
        if (exp16.size() + exp24.size() != 0) begin
            errors++; $display("FAIL early_pending got %0d want 0", exp16.size() + exp24.size());
        end
    endtask

    task automatic test_restart();
        logic [127:0] w, c16, c24;
        do_reset();
        preamble();
        w = rand_frame();
        push_exp(w);
        send_frame(w, 128, 64, -1, -1, c16, c24);
        send_frame(rand_frame(), 104, 64, -1, -1, c16, c24);
        send_frame(rand_frame(), 128, 64, -1, -1, c16, c24);
        checks++;
        if (se_cnt !== 1) begin errors++; $display("FAIL restart_se_count got %0d want 1", se_cnt); end
        w = rand_frame();
        push_exp(w);
        send_frame(w, 128, 64, -1, -1, c16, c24);
        checks++;
        if (dv_cnt !== 1) begin
            errors++; $display("FAIL restart_no_valid got %0d want 1", dv_cnt);
        end
        close_frame();
        checks++;
        if (fs_cnt !== 5) begin errors++; $display("FAIL restart_fs_count got %0d want 5", fs_cnt); end
        checks++;
        if (dv_cnt !== 2) begin errors++; $display("FAIL restart_dv_count got %0d want 2", dv_cnt); end
        checks++;
        if (exp16.size() + exp24.size() != 0) begin
            errors++; $display("FAIL restart_pending got %0d want 0", exp16.size() + exp24.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] w, c16, c24;
        do_reset();
        preamble();
        w = rand_frame();
        push_exp(w);
        send_frame(w, 128, 64, -1, -1, c16, c24);
        send_frame(rand_frame(), 128, 64, -1, 70, c16, c24);
        w = rand_frame();
        push_exp(w);
        send_frame(w, 128, 64, -1, -1, c16, c24);
        checks++;
        if (dv_cnt !== 1) begin
            errors++; $display("FAIL rstmid_no_valid got %0d want 1", dv_cnt);
        end
        close_frame();
        checks++;
        if (dv_cnt !== 2) begin errors++; $display("FAIL rstmid_dv_count got %0d want 2", dv_cnt); end
        checks++;
        if (se_cnt !== 0) begin errors++; $display("FAIL rstmid_se_count got %0d want 0", se_cnt); end
        checks++;
        if (exp16.size() + exp24.size() != 0) begin
            errors++; $display("FAIL rstmid_pending got %0d want 0", exp16.size() + exp24.size());
        end
    endtask

    task automatic test_stretch();
        logic [127:0] w, c16, c24;
        do_reset();
        adc16 = '{16'hC001, 16'h0BAD, 16'hF00D, 16'h4242};
        adc24 = '{24'hC00123, 24'h0BAD45, 24'hF00D67, 24'h424289};
        preamble();
        w = rand_frame();
        push_exp(w);
        send_frame(w, 128, 64, 45, -1, c16, c24);
        checks++;
        if (c16 !== tx16_model()) begin
            errors++; $display("FAIL stretch_tx16 got %h want %h", c16, tx16_model());
        end
        checks++;
        if (c24 !== tx24_model()) begin
            errors++; $display("FAIL stretch_tx24 got %h want %h", c24, tx24_model());
        end
        close_frame();
        checks++;
        if (se_cnt !== 0) begin errors++; $display("FAIL stretch_se_count got %0d want 0", se_cnt); end
        checks++;
        if (dv_cnt !== 1) begin errors++; $display("FAIL stretch_dv_count got %0d want 1", dv_cnt); end
        checks++;
        if (exp16.size() + exp24.size() != 0) begin
            errors++; $display("FAIL stretch_pending got %0d want 0", exp16.size() + exp24.size());
        end
    endtask

    initial begin
        adc16 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        adc24 = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        test_reset();
        test_loopback();
        test_lrck_early();
        test_restart();
        test_reset_mid();
        test_stretch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
